// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO serial transmit port.
// Status bit positions and default bus addresses live here.
package mmio_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;

  localparam logic [7:0] TX_ADDR_DEF     = 8'hFF;
  localparam logic [7:0] STATUS_ADDR_DEF = 8'hFE;

endpackage

// File: rtl/mmio_tx_port_fifo.sv
// Circular-pointer FIFO buffering CPU stores ahead of the serializer.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module sync_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DWIDTH-1:0]          din,
  output logic [DWIDTH-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next pointers, storage and occupancy
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + PW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; pointers gate what is visible
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_tx_port.sv
// Memory-mapped UART-style transmitter on the CPU store bus.
// Define MMIO_TX_PARITY_EN to add an even-parity bit after the data bits.
module mmio_tx_port
  import mmio_pkg::*;
#(
  parameter int                DWIDTH       = 8,
  parameter int                DEPTH        = 4,
  parameter logic [DWIDTH-1:0] TX_ADDR      = DWIDTH'(TX_ADDR_DEF),
  parameter logic [DWIDTH-1:0] STATUS_ADDR  = DWIDTH'(STATUS_ADDR_DEF),
  parameter int                CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [DWIDTH-1:0] dataadr,
  input  logic [DWIDTH-1:0] writedata,
  output logic [DWIDTH-1:0] readdata,
  output logic              tx,
  output logic              tx_busy,
  output logic              overflow
);

  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW  = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam int FCW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DWIDTH - 1);

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
`ifdef MMIO_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              push_req, clr_req, pop, drop;
  logic [DWIDTH-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [FCW-1:0]    fifo_cnt;

  assign push_req = memwrite && (dataadr == TX_ADDR);
  assign clr_req  = memwrite && (dataadr == STATUS_ADDR);
  // count is used here so a same-cycle pop rescues a store
  assign drop     = push_req && (fifo_cnt == FCW'(DEPTH)) && !pop;

  sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (writedata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Serializer next state, with tx derived from the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef MMIO_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
`ifdef MMIO_TX_PARITY_EN
          par_d   = ^fifo_dout;
`endif
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (bit_q == BIT_MAX) begin
`ifdef MMIO_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef MMIO_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_req) begin
      ovf_d = 1'b0;
    end
  end

  // State, counters, shifter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef MMIO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
`ifdef MMIO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Status read port, zero outside the status address
  always_comb begin
    readdata = '0;
    if (dataadr == STATUS_ADDR) begin
      readdata[ST_FULL]  = fifo_full;
      readdata[ST_EMPTY] = fifo_empty;
      readdata[ST_BUSY]  = busy_q;
      readdata[ST_OVF]   = ovf_q;
`ifdef MMIO_TX_PARITY_EN
      readdata[ST_PAR]   = 1'b1;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign overflow = ovf_q;

endmodule
